// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants used by ID, WB, hazard logic and the register file.
package mips_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned WCNT_W = 16;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

endpackage : mips_pkg

// File: rtl/mips_reg_file_if.sv
// Register-file bus: WB write port, ID read ports, debug read and write counter.
interface mips_reg_file_if
  import mips_pkg::*;
#(
  parameter int unsigned DW = mips_pkg::DATA_W,
  parameter int unsigned AW = mips_pkg::ADDR_W
) ();

  logic              RegWrite;
  logic [AW-1:0]     Write_Reg_Num;
  logic [DW-1:0]     reg_write_data;
  logic [AW-1:0]     rs;
  logic [AW-1:0]     rt;
  logic [DW-1:0]     Read_Data1;
  logic [DW-1:0]     Read_Data2;
  logic [AW-1:0]     dbg_addr;
  logic [DW-1:0]     dbg_data;
  logic [WCNT_W-1:0] wr_count;

  modport master (
    output RegWrite, Write_Reg_Num, reg_write_data, rs, rt, dbg_addr,
    input  Read_Data1, Read_Data2, dbg_data, wr_count
  );

  modport slave (
    input  RegWrite, Write_Reg_Num, reg_write_data, rs, rt, dbg_addr,
    output Read_Data1, Read_Data2, dbg_data, wr_count
  );

endinterface : mips_reg_file_if

// File: rtl/reg_read_port.sv
// One ID-stage read port: $zero check, WB write-through compare and output mux.
module reg_read_port
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W    = mips_pkg::DATA_W,
  parameter int unsigned ADDR_W    = mips_pkg::ADDR_W,
  parameter int unsigned BYPASS_EN = 1
) (
  input  logic [ADDR_W-1:0] i_idx,
  input  logic [DATA_W-1:0] i_stored,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_wr_idx,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic [DATA_W-1:0] o_data_c
);

  logic w_hit;

  assign w_hit = (BYPASS_EN != 0) && i_we && (i_idx == i_wr_idx);

  // $zero wins over bypass; bypass wins over stored value
  always_comb begin
    o_data_c = i_stored;
    if (i_idx == ADDR_W'(REG_ZERO)) begin
      o_data_c = '0;
    end else if (w_hit) begin
      o_data_c = i_wr_data;
    end
  end

endmodule : reg_read_port

// File: rtl/mips_reg_file.sv
// 32x32 MIPS GPR file: WB write port, two combinational ID read ports with
// optional same-cycle write-through, debug read of storage and a write counter.
module mips_reg_file
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W    = mips_pkg::DATA_W,
  parameter int unsigned ADDR_W    = mips_pkg::ADDR_W,
  parameter int unsigned BYPASS_EN = 1
) (
  input  logic           clk,
  input  logic           reset,
  mips_reg_file_if.slave bus
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_regs [1:DEPTH-1];
  logic [DATA_W-1:0] w_view [DEPTH];
  logic [WCNT_W-1:0] r_wr_count;
  logic              w_commit;
  logic [DATA_W-1:0] w_rd1;
  logic [DATA_W-1:0] w_rd2;

  assign w_commit = bus.RegWrite && (bus.Write_Reg_Num != ADDR_W'(REG_ZERO));

  // Storage update; index 0 has no storage so writes to it are dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 1; i < int'(DEPTH); i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_commit) begin
      r_regs[bus.Write_Reg_Num] <= bus.reg_write_data;
    end
  end

  // Committed-write counter, saturating at all ones
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_count <= '0;
    end else if (w_commit && (r_wr_count != '1)) begin
      r_wr_count <= r_wr_count + WCNT_W'(1);
    end
  end

  // Stored-value view with a constant zero at index 0
  always_comb begin
    w_view[0] = '0;
    for (int i = 1; i < int'(DEPTH); i++) begin
      w_view[i] = r_regs[i];
    end
  end

  reg_read_port #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .BYPASS_EN (BYPASS_EN)
  ) u_port_rs (
    .i_idx     (bus.rs),
    .i_stored  (w_view[bus.rs]),
    .i_we      (bus.RegWrite),
    .i_wr_idx  (bus.Write_Reg_Num),
    .i_wr_data (bus.reg_write_data),
    .o_data_c  (w_rd1)
  );

  reg_read_port #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .BYPASS_EN (BYPASS_EN)
  ) u_port_rt (
    .i_idx     (bus.rt),
    .i_stored  (w_view[bus.rt]),
    .i_we      (bus.RegWrite),
    .i_wr_idx  (bus.Write_Reg_Num),
    .i_wr_data (bus.reg_write_data),
    .o_data_c  (w_rd2)
  );

  assign bus.Read_Data1 = w_rd1;
  assign bus.Read_Data2 = w_rd2;
  assign bus.dbg_data   = w_view[bus.dbg_addr];
  assign bus.wr_count   = r_wr_count;

endmodule : mips_reg_file

// File: tb/tb_mips_reg_file.sv
// Directed bench for mips_reg_file: one bypassing and one non-bypassing
// instance driven with identical stimulus.
module tb_mips_reg_file;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  mips_reg_file_if b0 ();
  mips_reg_file_if b1 ();

  assign b1.RegWrite       = b0.RegWrite;
  assign b1.Write_Reg_Num  = b0.Write_Reg_Num;
  assign b1.reg_write_data = b0.reg_write_data;
  assign b1.rs             = b0.rs;
  assign b1.rt             = b0.rt;
  assign b1.dbg_addr       = b0.dbg_addr;

  mips_reg_file #(.BYPASS_EN(1)) u_byp (.clk(clk), .reset(rst), .bus(b0));
  mips_reg_file #(.BYPASS_EN(0)) u_nob (.clk(clk), .reset(rst), .bus(b1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [4:0] a, input logic [4:0] b, input logic [4:0] d);
    b0.RegWrite       = we;
    b0.Write_Reg_Num  = wa;
    b0.reg_write_data = wd;
    b0.rs             = a;
    b0.rt             = b;
    b0.dbg_addr       = d;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] wa, input logic [31:0] wd);
    set_in(1'b1, wa, wd, 5'd0, 5'd0, wa);
    step();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    set_in(1'b0, 5'd0, 32'h0, 5'd5, 5'd6, 5'd5);

    // reset state
    check("rst_rd1", b0.Read_Data1, 32'h0);
    check("rst_rd2", b0.Read_Data2, 32'h0);
    check("rst_dbg", b0.dbg_data, 32'h0);
    check("rst_cnt", 32'(b0.wr_count), 32'h0);

    @(negedge clk);
    rst = 1'b0;

    // async reset mid-cycle clears storage and counter
    wr(5'd5, 32'hDEADBEEF);
    check("r5_written", b0.dbg_data, 32'hDEADBEEF);
    check("cnt_after_r5", 32'(b0.wr_count), 32'h1);
    set_in(1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 5'd5);
    rst = 1'b1;
    #1;
    check("async_rst_dbg", b0.dbg_data, 32'h0);
    check("async_rst_cnt", 32'(b0.wr_count), 32'h0);
    check("async_rst_rd1", b0.Read_Data1, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // basic write/read on consecutive edges
    wr(5'd8, 32'h0000_1234);
    wr(5'd9, 32'hFFFF_0000);
    set_in(1'b0, 5'd0, 32'h0, 5'd8, 5'd9, 5'd8);
    check("basic_rd1", b0.Read_Data1, 32'h0000_1234);
    check("basic_rd2", b0.Read_Data2, 32'hFFFF_0000);
    check("basic_rd1_nob", b1.Read_Data1, 32'h0000_1234);
    check("basic_rd2_nob", b1.Read_Data2, 32'hFFFF_0000);
    check("basic_cnt", 32'(b0.wr_count), 32'h2);

    // $zero write is dropped and never bypassed
    set_in(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0);
    check("zero_rd1_pre", b0.Read_Data1, 32'h0);
    step();
    check("zero_rd1_post", b0.Read_Data1, 32'h0);
    check("zero_dbg", b0.dbg_data, 32'h0);
    check("zero_cnt", 32'(b0.wr_count), 32'h2);

    // same-cycle write-through
    wr(5'd3, 32'h11);
    set_in(1'b1, 5'd3, 32'h22, 5'd3, 5'd3, 5'd3);
    check("byp_rd1", b0.Read_Data1, 32'h22);
    check("byp_rd2", b0.Read_Data2, 32'h22);
    check("nob_rd1", b1.Read_Data1, 32'h11);
    check("nob_rd2", b1.Read_Data2, 32'h11);
    check("byp_dbg_pre", b0.dbg_data, 32'h11);
    step();
    set_in(1'b0, 5'd0, 32'h0, 5'd3, 5'd3, 5'd3);
    check("byp_dbg_post", b0.dbg_data, 32'h22);
    check("nob_rd1_post", b1.Read_Data1, 32'h22);
    check("byp_cnt", 32'(b0.wr_count), 32'h4);

    // RegWrite low: no bypass, no state change
    wr(5'd4, 32'h55);
    set_in(1'b0, 5'd4, 32'hAA, 5'd4, 5'd4, 5'd4);
    check("we0_rd1_pre", b0.Read_Data1, 32'h55);
    step();
    check("we0_rd1_post", b0.Read_Data1, 32'h55);
    check("we0_dbg_post", b0.dbg_data, 32'h55);
    check("we0_cnt", 32'(b0.wr_count), 32'h5);

    // ports evaluated independently: only rt matches the write
    set_in(1'b1, 5'd4, 32'h77, 5'd3, 5'd4, 5'd4);
    check("indep_rd1", b0.Read_Data1, 32'h22);
    check("indep_rd2", b0.Read_Data2, 32'h77);
    check("indep_rd2_nob", b1.Read_Data2, 32'h55);
    step();
    check("indep_cnt", 32'(b0.wr_count), 32'h6);

    // saturation: 65540 writes to r1, counter starting from 6
    for (int i = 0; i < 65540; i++) begin
      wr(5'd1, 32'(i));
      if (i == 65527) check("sat_cnt_fffe", 32'(b0.wr_count), 32'h0000_FFFE);
      if (i == 65528) check("sat_cnt_ffff", 32'(b0.wr_count), 32'h0000_FFFF);
    end
    check("sat_cnt_hold", 32'(b0.wr_count), 32'h0000_FFFF);
    check("sat_r1_last", b0.dbg_data, 32'h0001_0003);
    check("sat_cnt_nob", 32'(b1.wr_count), 32'h0000_FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mips_reg_file
